alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 16-bit single-cycle datapath ALU.
- Supports configurable WIDTH and a 4-bit op code: the eight classic ops plus XOR, SLTU and SRA, an iterative shift-add multiply, and iterative unsigned divide/remainder.
- Uses a valid/ready handshake on both sides so the CPU control can stall on long ops.
- Outputs a registered result plus zero, carry, overflow and error flags.

Parameters:
- WIDTH, 16: operand/result width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH): derived shift-index and counter width; not for override.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op are presented
- in_ready  out  1  block can accept an op
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (also the shift amount)
- ctrl  in  4  op code
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  ADD carry-out / SUB no-borrow (a ≥ b unsigned); 0 for other ops
- overflow  out  1  signed overflow for ADD/SUB; 0 for other ops
- err  out  1  divide-by-zero or illegal ctrl

Behaviour:
- ctrl encoding:
  - 0 AND, 1 OR, 2 ADD, 3 SLL, 4 NOR, 5 SRL, 6 SUB, 7 SLT (signed)
  - 8 SLTU, 9 SRA, 10 XOR, 11 MUL (low WIDTH bits of a*b), 12 DIVU, 13 REMU
  - 14–15 illegal
- Shifts:
  - The full b is the amount.
  - b ≥ WIDTH gives 0 for SLL/SRL.
  - b ≥ WIDTH gives {WIDTH{a[WIDTH-1]}} for SRA.
- SLT/SLTU produce 1 or 0, zero-extended to WIDTH.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE). No other condition drives in_ready.
  - IDLE, handshake (in_valid & in_ready) on cycle N:
    - Latch a, b and ctrl.
    - Single-cycle ops, divide-by-zero and illegal ops: compute the result and go to DONE. out_valid is high at N+1.
    - MUL/DIVU/REMU: go to BUSY with counter = 0.
  - BUSY:
    - One iteration per cycle: MUL uses shift-add over b bits, LSB first; DIVU/REMU use a restoring step, MSB first.
    - After WIDTH iterations, go to DONE. out_valid is high at N+WIDTH+1.
    - in_valid is ignored because in_ready is low.
  - DONE:
    - out_valid = 1.
    - result and all flags are held stable until out_ready.
    - On out_valid & out_ready, go to IDLE; in_ready rises the next cycle.
    - Minimum issue interval is 2 cycles for single-cycle ops.
- Arithmetic:
  - Sums use WIDTH+1 bits internally.
  - carry = bit WIDTH of a + b (ADD), or of a + ~b + 1 (SUB).
  - overflow = (a[MSB]==b'[MSB]) & (r[MSB]!=a[MSB]), where b' = b for ADD and ~b for SUB.
  - MUL discards the upper WIDTH bits.
- Divide by zero (b == 0 on DIVU/REMU):
  - Completes in 1 cycle with err = 1.
  - DIVU result = all ones; REMU result = a.
- Illegal ctrl: result = 0, err = 1, zero = 1, 1-cycle latency.
- zero is computed from the registered result and is valid only while out_valid.
- Reset (asserted asynchronously, including mid-BUSY or in DONE):
  - state = IDLE, in_ready = 1 after release.
  - out_valid, result, carry, overflow and err are all 0.
  - zero = 1, and the in-flight op is discarded.
- Operand inputs may change freely while not being accepted; only latched values are used.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined: DIVU/REMU are implemented as above.
- Undefined:
  - No divider hardware is generated.
  - ctrl 12/13 are treated as illegal (result 0, err 1, 1-cycle latency).
  - MUL is unaffected.

Test Plan (WIDTH = 16):
- Reset, then ADD a=0x7FFF b=0x0001, out_ready=1:
  - out_valid at N+1.
  - result=0x8000, overflow=1, carry=0, zero=0.
  - in_ready returns to 1 the cycle after the handshake.
- SUB a=5 b=5 → result=0, zero=1, carry=1. SLT a=0xFFFF b=0x0001 → 1; SLTU with the same operands → 0.
- SRA a=0x8000 b=20 → 0xFFFF. SLL a=0x0001 b=15 → 0x8000. SRL a=0x8000 b=16 → 0.
- MUL a=300 b=300 with out_ready held low for 5 cycles:
  - out_valid first high at N+17.
  - result=0x5F90, stable through the stall.
  - in_ready stays 0 and a concurrent in_valid is ignored.
- DIVU a=1000 b=7 → 142 at N+17. REMU → 6. DIVU b=0 → 0xFFFF with err=1 at N+1. With ALU_MC_DIV_EN undefined, DIVU → 0 with err=1.
- Assert rst_n=0 mid-MUL (counter ≈ 8):
  - out_valid drops immediately and all outputs take reset values.
  - After release, ADD 2+3 returns 5 with no residue of the aborted op.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle WIDTH-bit ALU behind valid/ready handshakes.
// Define ALU_MC_DIV_EN to build the iterative DIVU/REMU unit.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;
`endif

  localparam logic [WIDTH-1:0] WLIM  = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   CLAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc, sh, rb;
  logic [WIDTH-1:0] acc_nx, sh_nx, rb_nx, fin;

  logic             is_sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             lt_s, lt_u;
  logic             big;
  logic [SHW-1:0]   amt;

  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_err;
  logic             multi;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero      = (result == '0);

  // Shared adder: SUB is a + ~b + 1
  always_comb begin
    is_sub = (ctrl == OP_SUB);
    bx     = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(is_sub);
    ovf    = (a[WIDTH-1] == bx[WIDTH-1]) &
             (sum[WIDTH-1] != a[WIDTH-1]);
    lt_s   = $signed(a) < $signed(b);
    lt_u   = a < b;
    big    = (b >= WLIM);
    amt    = b[SHW-1:0];
  end

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    multi  = 1'b0;
    unique case (ctrl)
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_NOR: sc_res = ~(a | b);
      OP_XOR: sc_res = a ^ b;
      OP_ADD, OP_SUB: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = ovf;
      end
      OP_SLL: sc_res = big ? '0 : (a << amt);
      OP_SRL: sc_res = big ? '0 : (a >> amt);
      OP_SRA: sc_res = big ? {WIDTH{a[WIDTH-1]}}
                           : WIDTH'($signed(a) >>> amt);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_MUL:  multi  = 1'b1;
`ifdef ALU_MC_DIV_EN
      OP_DIVU: begin
        if (b == '0) begin
          sc_res = '1;
          sc_err = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
      OP_REMU: begin
        if (b == '0) begin
          sc_res = a;
          sc_err = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

`ifdef ALU_MC_DIV_EN
  logic [3:0]     rop;
  logic [WIDTH:0] rem_sh, diff;

  always_comb begin
    rem_sh = {acc, sh[WIDTH-1]};
    diff   = rem_sh - {1'b0, rb};
  end
`endif

  // acc: product / partial remainder; sh: multiplicand / dividend->quotient
  always_comb begin
    acc_nx = acc + (rb[0] ? sh : '0);
    sh_nx  = sh << 1;
    rb_nx  = rb >> 1;
    fin    = acc_nx;
`ifdef ALU_MC_DIV_EN
    if (rop != OP_MUL) begin
      rb_nx = rb;
      if (!diff[WIDTH]) begin
        acc_nx = diff[WIDTH-1:0];
        sh_nx  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[WIDTH-1:0];
        sh_nx  = {sh[WIDTH-2:0], 1'b0};
      end
      fin = (rop == OP_DIVU) ? sh_nx : acc_nx;
    end
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = multi ? BUSY : DONE;
      BUSY: if (cnt == CLAST) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      sh       <= '0;
      rb       <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
`ifdef ALU_MC_DIV_EN
      rop      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cnt      <= '0;
            acc      <= '0;
            sh       <= a;
            rb       <= b;
            result   <= sc_res;
            carry    <= sc_c;
            overflow <= sc_v;
            err      <= sc_err;
`ifdef ALU_MC_DIV_EN
            rop      <= ctrl;
`endif
          end
        end
        BUSY: begin
          acc <= acc_nx;
          sh  <= sh_nx;
          rb  <= rb_nx;
          cnt <= cnt + SHW'(1);
          if (cnt == CLAST) result <= fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc at WIDTH = 16.
// Division vectors follow the ALU_MC_DIV_EN build setting.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] op,
                        input logic [15:0] x,
                        input logic [15:0] y,
                        input int lat,
                        input logic [15:0] er,
                        input logic ec,
                        input logic ev,
                        input logic ee,
                        input logic ez);
    int n;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(in_ready), 1);
    ctrl = op;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hdead;
    b = 16'hbeef;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".res"}, 32'(result), 32'(er));
    chk({tag, ".c"}, 32'(carry), 32'(ec));
    chk({tag, ".v"}, 32'(overflow), 32'(ev));
    chk({tag, ".err"}, 32'(err), 32'(ee));
    chk({tag, ".z"}, 32'(zero), 32'(ez));
    if (out_ready) begin
      @(negedge clk);
      chk({tag, ".rdy2"}, 32'(in_ready), 1);
      chk({tag, ".ov0"}, 32'(out_valid), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    ctrl = '0;
    repeat (2) @(negedge clk);
    chk("rst.ov", 32'(out_valid), 0);
    chk("rst.res", 32'(result), 0);
    chk("rst.z", 32'(zero), 1);
    chk("rst.flags", 32'({carry, overflow, err}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.rdy", 32'(in_ready), 1);

    run_op("add_ovf", 4'd2, 16'h7fff, 16'h0001, 1, 16'h8000, 0, 1, 0, 0);
    run_op("add_c",   4'd2, 16'hffff, 16'h0001, 1, 16'h0000, 1, 0, 0, 1);
    run_op("sub_eq",  4'd6, 16'd5,    16'd5,    1, 16'h0000, 1, 0, 0, 1);
    run_op("sub_brw", 4'd6, 16'd3,    16'd5,    1, 16'hfffe, 0, 0, 0, 0);
    run_op("sub_ovf", 4'd6, 16'h8000, 16'h0001, 1, 16'h7fff, 1, 1, 0, 0);
    run_op("and",     4'd0, 16'hf0f0, 16'hff00, 1, 16'hf000, 0, 0, 0, 0);
    run_op("or",      4'd1, 16'hf0f0, 16'h0f0f, 1, 16'hffff, 0, 0, 0, 0);
    run_op("nor",     4'd4, 16'h00ff, 16'h0f00, 1, 16'hf000, 0, 0, 0, 0);
    run_op("xor",     4'd10, 16'haaaa, 16'hffff, 1, 16'h5555, 0, 0, 0, 0);
    run_op("slt",     4'd7, 16'hffff, 16'h0001, 1, 16'h0001, 0, 0, 0, 0);
    run_op("sltu",    4'd8, 16'hffff, 16'h0001, 1, 16'h0000, 0, 0, 0, 1);
    run_op("sra_big", 4'd9, 16'h8000, 16'd20,   1, 16'hffff, 0, 0, 0, 0);
    run_op("sra4",    4'd9, 16'h8000, 16'd4,    1, 16'hf800, 0, 0, 0, 0);
    run_op("sll15",   4'd3, 16'h0001, 16'd15,   1, 16'h8000, 0, 0, 0, 0);
    run_op("srl_big", 4'd5, 16'h8000, 16'd16,   1, 16'h0000, 0, 0, 0, 1);
    run_op("srl4",    4'd5, 16'h8000, 16'd4,    1, 16'h0800, 0, 0, 0, 0);
    run_op("ill14",   4'd14, 16'h1234, 16'h5678, 1, 16'h0000, 0, 0, 1, 1);
    run_op("mul_ff",  4'd11, 16'hffff, 16'hffff, 17, 16'h0001, 0, 0, 0, 0);
`ifdef ALU_MC_DIV_EN
    run_op("divu",    4'd12, 16'd1000, 16'd7, 17, 16'd142, 0, 0, 0, 0);
    run_op("remu",    4'd13, 16'd1000, 16'd7, 17, 16'd6,   0, 0, 0, 0);
    run_op("divu0",   4'd12, 16'd1000, 16'd0, 1, 16'hffff, 0, 0, 1, 0);
    run_op("remu0",   4'd13, 16'd1234, 16'd0, 1, 16'd1234, 0, 0, 1, 0);
`else
    run_op("divu_ill", 4'd12, 16'd1000, 16'd7, 1, 16'h0000, 0, 0, 1, 1);
    run_op("remu_ill", 4'd13, 16'd1000, 16'd7, 1, 16'h0000, 0, 0, 1, 1);
`endif

    // MUL with stalled consumer and an ignored request while busy
    out_ready = 1'b0;
    @(negedge clk);
    ctrl = 4'd11;
    a = 16'd300;
    b = 16'd300;
    in_valid = 1'b1;
    @(negedge clk);
    n = 1;
    ctrl = 4'd2;
    a = 16'd1;
    b = 16'd1;
    chk("mul.busy_rdy", 32'(in_ready), 0);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 4) in_valid = 1'b0;
    end
    chk("mul.lat", 32'(n), 17);
    chk("mul.res", 32'(result), 32'h5f90);
    repeat (5) begin
      @(negedge clk);
      chk("mul.hold", 32'({out_valid, in_ready, result}), 32'h25f90);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("mul.rdy2", 32'(in_ready), 1);
    @(negedge clk);
    chk("mul.noghost", 32'(out_valid), 0);

    // Reset while holding an error result in DONE
    out_ready = 1'b0;
    run_op("ill15", 4'd15, 16'h0001, 16'h0001, 1, 16'h0000, 0, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done.ov", 32'(out_valid), 0);
    chk("rst_done.err", 32'(err), 0);
    chk("rst_done.rdy", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Reset in the middle of a MUL
    @(negedge clk);
    ctrl = 4'd11;
    a = 16'h7fff;
    b = 16'h7fff;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mul.busy", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mul.ov", 32'(out_valid), 0);
    chk("rst_mul.res", 32'(result), 0);
    chk("rst_mul.z", 32'(zero), 1);
    chk("rst_mul.flags", 32'({carry, overflow, err}), 0);
    chk("rst_mul.rdy", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_post", 4'd2, 16'd2, 16'd3, 1, 16'd5, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
